// File: rtl/tx_serial_param.sv
// -----------------------------------------------------------------------------
// tx_serial_param
//   Parametrised asynchronous serial transmitter with a one-entry holding
//   register, so the next character can be queued while the current frame
//   shifts out. Internal bit-period tick generator.
//
//   Frame on the line (LSB first): start 0, DATA_BITS data, optional parity,
//   STOP_BITS stop 1s. Each bit lasts exactly CLK_DIV clocks.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//   CLK_DIV    clocks per bit (>= 2)
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   partida       in   write request
//   dados         in   character, captured when partida && livre
//   livre         out  holding register empty
//   ocupado       out  frame in progress (state != OCIOSO)
//   pronto        out  1-cycle pulse when the last stop bit ends
//   descartado    out  1-cycle pulse: partida while full, character dropped
//   saida_serial  out  serial line, idles high
//   db_tick       out  bit-period tick
//   db_estado     out  FSM state code
//
// Handshake: a write is taken on a rising edge where partida = 1 and
// livre = 1. A write seen while livre = 0 is dropped and flagged by
// descartado on the following cycle; there is no back-pressure beyond livre.
// -----------------------------------------------------------------------------
module tx_serial_param #(
    parameter int DATA_BITS = 7,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1,
    parameter int CLK_DIV   = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 partida,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 livre,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 descartado,
    output logic                 saida_serial,
    output logic                 db_tick,
    output logic [3:0]           db_estado
);

    localparam int NPAR  = (PARITY != 0) ? 1 : 0;
    localparam int NBITS = 1 + DATA_BITS + NPAR + STOP_BITS;
    localparam int CW    = $clog2(CLK_DIV);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    BIT_LAST = 4'(NBITS - 1);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CARREGA   = 2'd1,
        TRANSMITE = 2'd2,
        FINAL     = 2'd3
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_hr;
    logic                 r_hr_full;
    logic [NBITS-1:0]     r_shift;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit;
    logic                 r_saida;
    logic                 r_ocupado;
    logic                 r_pronto;
    logic                 r_desc;
    logic                 r_tick;

    logic                 w_tick;
    logic                 w_parity;
    logic [NBITS-1:0]     w_frame;

    // Internal tick; r_tick is the registered copy that appears on db_tick
    // during the same cycle the counter sits at CNT_MAX.
    assign w_tick   = (r_cnt == CNT_MAX);
    assign w_parity = (^r_hr) ^ (PARITY == 2);

    // Frame image: stop bits are the default 1s in the top positions.
    always_comb begin
        w_frame              = '1;
        w_frame[0]           = 1'b0;
        w_frame[DATA_BITS:1] = r_hr;
        if (NPAR != 0) begin
            w_frame[DATA_BITS+1] = w_parity;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= OCIOSO;
            r_hr      <= '0;
            r_hr_full <= 1'b0;
            r_shift   <= '1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_saida   <= 1'b1;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_desc    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            r_tick   <= 1'b0;
            r_desc   <= partida && r_hr_full;

            // Accept a new character only when the holding register is empty.
            // In CARREGA r_hr_full is still 1, so a write there is dropped.
            if (partida && !r_hr_full) begin
                r_hr      <= dados;
                r_hr_full <= 1'b1;
            end

            case (r_state)
                OCIOSO: begin
                    r_saida <= 1'b1;
                    if (r_hr_full) begin
                        r_state   <= CARREGA;
                        r_ocupado <= 1'b1;
                    end else begin
                        r_ocupado <= 1'b0;
                    end
                end

                CARREGA: begin
                    r_shift   <= w_frame;
                    r_hr_full <= 1'b0;
                    r_cnt     <= '0;
                    r_bit     <= '0;
                    r_saida   <= 1'b0;  // start bit goes out next cycle
                    r_ocupado <= 1'b1;
                    r_state   <= TRANSMITE;
                end

                TRANSMITE: begin
                    r_ocupado <= 1'b1;
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 4'd1;
                        r_cnt   <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state  <= FINAL;
                            r_saida  <= 1'b1;
                            r_pronto <= 1'b1;
                        end else begin
                            r_saida <= r_shift[1];
                        end
                    end else begin
                        r_cnt  <= r_cnt + CNT_ONE;
                        r_tick <= ((r_cnt + CNT_ONE) == CNT_MAX);
                    end
                end

                FINAL: begin
                    r_saida <= 1'b1;
                    if (r_hr_full) begin
                        r_state   <= CARREGA;
                        r_ocupado <= 1'b1;
                    end else begin
                        r_state   <= OCIOSO;
                        r_ocupado <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= OCIOSO;
                    r_saida   <= 1'b1;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign livre        = ~r_hr_full;
    assign ocupado      = r_ocupado;
    assign pronto       = r_pronto;
    assign descartado   = r_desc;
    assign saida_serial = r_saida;
    assign db_tick      = r_tick;
    assign db_estado    = {2'b00, r_state};

endmodule

// File: tb/tb_tx_serial_param.sv
// -----------------------------------------------------------------------------
// tb_tx_serial_param
//   Four transmitter instances in different configurations share clock and
//   reset; one is selected at a time. Expected line bits are pushed when a
//   character is written and popped as each bit appears on the line.
//     sel 0: 7O1, CLK_DIV 434 (defaults)
//     sel 1: 8N2, CLK_DIV 4
//     sel 2: 7E1, CLK_DIV 4
//     sel 3: 7O1, CLK_DIV 4
// -----------------------------------------------------------------------------
module tb_tx_serial_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] partida_v = '0;
    logic [8:0] dados_v = '0;

    logic [3:0] s_line, s_livre, s_ocup, s_pronto, s_desc, s_tick;
    logic [3:0] s_est [4];

    logic [1:0] sel = 2'd0;
    logic       m_line, m_livre, m_ocup, m_pronto, m_desc, m_tick;
    logic [3:0] m_est;

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_q[$];

    always #5 clock = ~clock;

    tx_serial_param u_def (
        .clock(clock), .reset(reset), .partida(partida_v[0]), .dados(dados_v[6:0]),
        .livre(s_livre[0]), .ocupado(s_ocup[0]), .pronto(s_pronto[0]),
        .descartado(s_desc[0]), .saida_serial(s_line[0]), .db_tick(s_tick[0]),
        .db_estado(s_est[0])
    );

    tx_serial_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLK_DIV(4)) u_8n2 (
        .clock(clock), .reset(reset), .partida(partida_v[1]), .dados(dados_v[7:0]),
        .livre(s_livre[1]), .ocupado(s_ocup[1]), .pronto(s_pronto[1]),
        .descartado(s_desc[1]), .saida_serial(s_line[1]), .db_tick(s_tick[1]),
        .db_estado(s_est[1])
    );

    tx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLK_DIV(4)) u_7e1 (
        .clock(clock), .reset(reset), .partida(partida_v[2]), .dados(dados_v[6:0]),
        .livre(s_livre[2]), .ocupado(s_ocup[2]), .pronto(s_pronto[2]),
        .descartado(s_desc[2]), .saida_serial(s_line[2]), .db_tick(s_tick[2]),
        .db_estado(s_est[2])
    );

    tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLK_DIV(4)) u_7o1 (
        .clock(clock), .reset(reset), .partida(partida_v[3]), .dados(dados_v[6:0]),
        .livre(s_livre[3]), .ocupado(s_ocup[3]), .pronto(s_pronto[3]),
        .descartado(s_desc[3]), .saida_serial(s_line[3]), .db_tick(s_tick[3]),
        .db_estado(s_est[3])
    );

    assign m_line   = s_line[sel];
    assign m_livre  = s_livre[sel];
    assign m_ocup   = s_ocup[sel];
    assign m_pronto = s_pronto[sel];
    assign m_desc   = s_desc[sel];
    assign m_tick   = s_tick[sel];
    assign m_est    = s_est[sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, parity, stop bits.
    task automatic push_frame(input logic [8:0] d, input int dbits, input int par,
                              input int stops);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 1) exp_q.push_back(p);
        if (par == 2) exp_q.push_back(~p);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // One-cycle write pulse; returns on the negedge right after the sampling edge.
    task automatic send(input logic [8:0] d, input int dbits, input int par, input int stops);
        @(negedge clock);
        dados_v = d;
        partida_v[sel] = 1'b1;
        push_frame(d, dbits, par, stops);
        @(negedge clock);
        partida_v[sel] = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (m_line !== 1'b0 && lat < 20);
        chk(tag, lat, exp_lat);
    endtask

    // Called on the first cycle of the start bit. Checks every cycle of every
    // bit; optionally injects one or two writes mid-frame (the second is
    // expected to be dropped because the first fills the holding register).
    task automatic check_frame(input string tag, input int div, input int nb,
                               input int n_inj, input logic [8:0] d1, input int dbits,
                               input int par, input int stops);
        logic [0:0] e;
        logic       line_bad, tick_bad, misc_bad;
        int         k;
        k = 0;
        misc_bad = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_underflow"}, 0, 1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            line_bad = 1'b0;
            tick_bad = 1'b0;
            for (int c = 0; c < div; c++) begin
                if (m_line !== e[0]) line_bad = 1'b1;
                if (m_tick !== (c == div - 1)) tick_bad = 1'b1;
                if (m_pronto !== 1'b0 || m_ocup !== 1'b1 || m_est !== 4'd2) misc_bad = 1'b1;
                if (n_inj >= 1 && k == 5) begin
                    dados_v = d1;
                    partida_v[sel] = 1'b1;
                    push_frame(d1, dbits, par, stops);
                end
                if (n_inj >= 1 && k == 6) begin
                    partida_v[sel] = 1'b0;
                    chk({tag, "_inj1_desc"}, m_desc, 0);
                    chk({tag, "_inj1_livre"}, m_livre, 0);
                end
                if (n_inj >= 2 && k == 9) begin
                    dados_v = 9'h1C3;
                    partida_v[sel] = 1'b1;
                end
                if (n_inj >= 2 && k == 10) begin
                    partida_v[sel] = 1'b0;
                    chk({tag, "_inj2_desc"}, m_desc, 1);
                end
                if (n_inj >= 2 && k == 11) chk({tag, "_desc_pulse_end"}, m_desc, 0);
                k++;
                if (!(b == nb - 1 && c == div - 1)) @(negedge clock);
            end
            chk({tag, "_line_bit"}, line_bad ? {31'd0, ~e[0]} : {31'd0, e[0]}, {31'd0, e[0]});
            chk({tag, "_tick_bit"}, tick_bad, 0);
        end
        chk({tag, "_status_in_frame"}, misc_bad, 0);
    endtask

    // FINAL cycle right after the last stop bit.
    task automatic check_final(input string tag, input logic exp_livre);
        @(negedge clock);
        chk({tag, "_pronto"}, m_pronto, 1);
        chk({tag, "_final_line"}, m_line, 1);
        chk({tag, "_final_state"}, m_est, 3);
        chk({tag, "_final_livre"}, m_livre, exp_livre);
    endtask

    task automatic check_idle(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (m_line !== 1'b1 || m_est !== 4'd0 || m_pronto !== 1'b0 || m_ocup !== 1'b0)
                bad = 1'b1;
        end
        chk({tag, "_idle"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_line", m_line, 1);
            chk("rst_livre", m_livre, 1);
            chk("rst_ocupado", m_ocup, 0);
            chk("rst_pronto", m_pronto, 0);
            chk("rst_desc", m_desc, 0);
            chk("rst_tick", m_tick, 0);
            chk("rst_estado", m_est, 0);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Default config, 'h41: 434 clocks per bit, pronto 4342 clocks after write
        sel = 2'd0;
        send(9'h041, 7, 2, 1);
        wait_start("def_latency", 2);
        chk("def_livre_after_load", m_livre, 1);
        check_frame("def", 434, 10, 0, 9'h0, 7, 2, 1);
        check_final("def", 1'b1);
        check_idle("def", 8);

        // 8N2, CLK_DIV 4, 'hA5
        sel = 2'd1;
        send(9'h0A5, 8, 0, 2);
        wait_start("n82_latency", 2);
        check_frame("n82", 4, 11, 0, 9'h0, 8, 0, 2);
        check_final("n82", 1'b1);
        check_idle("n82", 6);

        // Parity even / odd on 'h07
        sel = 2'd2;
        send(9'h007, 7, 1, 1);
        wait_start("e71_latency", 2);
        check_frame("e71", 4, 10, 0, 9'h0, 7, 1, 1);
        check_final("e71", 1'b1);
        sel = 2'd3;
        send(9'h007, 7, 2, 1);
        wait_start("o71_latency", 2);
        check_frame("o71", 4, 10, 0, 9'h0, 7, 2, 1);
        check_final("o71", 1'b1);
        check_idle("o71", 6);

        // Queued frame: 'h42 written mid-frame, gap of exactly FINAL + CARREGA
        send(9'h041, 7, 2, 1);
        wait_start("q1_latency", 2);
        check_frame("q1", 4, 10, 1, 9'h042, 7, 2, 1);
        check_final("q1", 1'b0);
        wait_start("q2_gap", 2);
        check_frame("q2", 4, 10, 0, 9'h0, 7, 2, 1);
        check_final("q2", 1'b1);
        check_idle("q2", 12);

        // Overrun: second write queued, third dropped, only two frames out
        send(9'h055, 7, 2, 1);
        wait_start("ov1_latency", 2);
        check_frame("ov1", 4, 10, 2, 9'h02A, 7, 2, 1);
        check_final("ov1", 1'b0);
        wait_start("ov2_gap", 2);
        check_frame("ov2", 4, 10, 0, 9'h0, 7, 2, 1);
        check_final("ov2", 1'b1);
        check_idle("ov2", 16);

        // Reset during data bit 3 (bit index 4 of the frame)
        send(9'h041, 7, 2, 1);
        wait_start("rm_latency", 2);
        repeat (17) @(negedge clock);
        chk("rm_midframe_state", m_est, 2);
        reset = 1'b0;
        #1;
        chk("rm_line", m_line, 1);
        chk("rm_estado", m_est, 0);
        chk("rm_livre", m_livre, 1);
        chk("rm_ocupado", m_ocup, 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(9'h06B, 7, 2, 1);
        wait_start("rm_new_latency", 2);
        check_frame("rm_new", 4, 10, 0, 9'h0, 7, 2, 1);
        check_final("rm_new", 1'b1);
        check_idle("rm_new", 6);

        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
